// File: rtl/control_sumator_multiprecizie.sv
// control_sumator_multiprecizie: multi-word adder sequencing one shared 16-bit CLA slice by slice (optional subtract via SUMATOR_SUB_EN)
module sumator_CAL_16biti (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] suma,
    output logic        c_out
);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  pg;
    // 4-bit group lookahead, then group-level carry lookahead across the 4 groups
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        gg = '0;
        pg = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            pg[j] = &p[4*j +: 4];
        end
        c[0]  = c_in;
        c[4]  = gg[0] | (pg[0] & c[0]);
        c[8]  = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & c[0]);
        c[12] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & c[0]);
        c[16] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
              | (pg[3] & pg[2] & pg[1] & pg[0] & c[0]);
        for (int j = 0; j < 4; j++)
            for (int k = 0; k < 3; k++)
                c[4*j+k+1] = g[4*j+k] | (p[4*j+k] & c[4*j+k]);
        suma  = p ^ c[15:0];
        c_out = c[16];
    end
endmodule

module control_sumator_multiprecizie #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] A,
    input  logic [16*WORDS-1:0] B,
    input  logic                C_in,
`ifdef SUMATOR_SUB_EN
    input  logic                sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] Suma,
    output logic                C_out,
    output logic                busy
);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic                    carry_reg;
    logic [WORDS-1:0][15:0]  a_reg;
    logic [WORDS-1:0][15:0]  b_reg;
    logic [WORDS-1:0][15:0]  res_reg;
    logic [WORDS-1:0][15:0]  next_res;
    logic [15:0]             slice_sum;
    logic                    slice_c;

    sumator_CAL_16biti u_cla (
        .a     (a_reg[idx]),
        .b     (b_reg[idx]),
        .c_in  (carry_reg),
        .suma  (slice_sum),
        .c_out (slice_c)
    );

    assign in_ready = (state == IDLE) && !rst;
    assign busy     = (state == RUN);

    // Result with the current slice merged in, so the last slice lands in Suma on the same edge
    always_comb begin
        next_res      = res_reg;
        next_res[idx] = slice_sum;
    end

    // Sequencer: accept operands, walk the slices LSW first, hold the result until taken
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            Suma      <= '0;
            C_out     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= A;
`ifdef SUMATOR_SUB_EN
                    b_reg     <= sub ? ~B : B;
                    carry_reg <= sub ? 1'b1 : C_in;
`else
                    b_reg     <= B;
                    carry_reg <= C_in;
`endif
                    idx   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    res_reg   <= next_res;
                    carry_reg <= slice_c;
                    if (idx == IW'(WORDS - 1)) begin
                        state     <= DONE;
                        idx       <= '0;
                        Suma      <= next_res;
                        C_out     <= slice_c;
                        out_valid <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
